// File: rtl/shift_seq_pkg.sv
// Shared FSM state type and per-pass step limit for the shift sequencer.
package shift_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int max_step(input int ctrl_w);
      return (1 << ctrl_w) - 1;
   endfunction

endpackage

// File: rtl/shift_step_splitter.sv
// Splits the remaining shift into one shifter pass; with SHIFT_SEQ_STICKY_EN
// it also reports whether that pass drops any set bits.
module shift_step_splitter
   import shift_seq_pkg::*;
#(
   parameter int N      = 8,
   parameter int CTRL_W = 2,
   parameter int AMT_W  = 4
) (
   input  logic [AMT_W-1:0]  rem,
   output logic [CTRL_W-1:0] step
`ifdef SHIFT_SEQ_STICKY_EN
   ,
   input  logic [N-1:0]      acc,
   output logic              lost
`endif
);

   localparam int MAX_STEP = max_step(CTRL_W);

   always_comb begin
      if (32'(rem) >= 32'(MAX_STEP)) step = CTRL_W'(MAX_STEP);
      else                           step = CTRL_W'(rem);
   end

`ifdef SHIFT_SEQ_STICKY_EN
   logic [N-1:0] mask;

   // Low STEP bits of the operand fall off the end this pass.
   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) mask[i] = (i < int'(step));
      lost = |(acc & mask);
   end
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass logical right shift over a narrow external shifter stage.
// Define SHIFT_SEQ_STICKY_EN to add the OUT_STICKY shifted-out indicator.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int N      = 8,
   parameter int CTRL_W = 2,
   parameter int AMT_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [N-1:0]      IN_DATA,
   input  logic [AMT_W-1:0]  IN_AMT,
   output logic [N-1:0]      SH_IN,
   output logic [CTRL_W-1:0] SH_CTRL,
   input  logic [N-1:0]      SH_OUT,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [N-1:0]      OUT_DATA
`ifdef SHIFT_SEQ_STICKY_EN
   ,
   output logic              OUT_STICKY
`endif
);

   state_e             state_q, state_d;
   logic [N-1:0]       acc_q, acc_d;
   logic [AMT_W-1:0]   rem_q, rem_d;
   logic [CTRL_W-1:0]  step;
`ifdef SHIFT_SEQ_STICKY_EN
   logic               sticky_q, sticky_d;
   logic               lost;
`endif

   shift_step_splitter #(
      .N      (N),
      .CTRL_W (CTRL_W),
      .AMT_W  (AMT_W)
   ) u_split (
      .rem  (rem_q),
      .step (step)
`ifdef SHIFT_SEQ_STICKY_EN
      ,
      .acc  (acc_q),
      .lost (lost)
`endif
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
`ifdef SHIFT_SEQ_STICKY_EN
      sticky_d = sticky_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (IN_VALID) begin
               acc_d = IN_DATA;
               rem_d = IN_AMT;
`ifdef SHIFT_SEQ_STICKY_EN
               sticky_d = 1'b0;
`endif
               if (IN_AMT == '0) begin
                  state_d = DONE;
               end else if (32'(IN_AMT) >= 32'(N)) begin
                  // Whole operand shifted out: skip the shifter entirely.
                  state_d = DONE;
                  acc_d   = '0;
`ifdef SHIFT_SEQ_STICKY_EN
                  sticky_d = |IN_DATA;
`endif
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            acc_d = SH_OUT;
            rem_d = rem_q - AMT_W'(step);
`ifdef SHIFT_SEQ_STICKY_EN
            sticky_d = sticky_q | lost;
`endif
            if (rem_d == '0) state_d = DONE;
         end
         DONE: begin
            if (OUT_READY) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
      end
   end

`ifdef SHIFT_SEQ_STICKY_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sticky_q <= 1'b0;
      else     sticky_q <= sticky_d;
   end

   assign OUT_STICKY = OUT_VALID ? sticky_q : 1'b0;
`endif

   assign IN_READY  = (state_q == IDLE);
   assign OUT_VALID = (state_q == DONE);
   assign OUT_DATA  = OUT_VALID ? acc_q : '0;
   assign SH_IN     = acc_q;
   assign SH_CTRL   = (state_q == RUN) ? step : '0;

endmodule
